// File: rtl/dice_roll_scheduler.sv
// dice_roll_scheduler: round-robin front end that shares one dice roller
// among NUM_REQ requesters. Each grant drives the die code, waits for it to
// settle, strobes a roll, range-checks the sample and retries through a
// roller reset before giving up with an error.
module dice_roll_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_die,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [4:0]             result,
  output logic                   error,
  output logic                   busy,
  output logic [15:0]            roll_count,
  output logic [2:0]             roller_die,
  output logic                   roller_roll,
  output logic                   roller_reset,
  input  logic [4:0]             roller_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ROLL,
    S_CHECK,
    S_DONE
  } state_t;

  // Number of faces for a die code; zero marks an invalid code.
  function automatic logic [4:0] sides_of(input logic [2:0] code);
    case (code)
      3'b001:  sides_of = 5'd4;
      3'b010:  sides_of = 5'd6;
      3'b011:  sides_of = 5'd8;
      3'b100:  sides_of = 5'd10;
      3'b101:  sides_of = 5'd12;
      3'b110:  sides_of = 5'd20;
      default: sides_of = 5'd0;
    endcase
  endfunction

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_winner;
  logic [2:0]         r_code;
  logic [SET_W-1:0]   r_settle;
  logic [RTY_W-1:0]   r_retry;
  logic               r_err;
  logic [4:0]         r_result;
  logic [15:0]        r_roll_count;
  logic [2:0]         r_roller_die;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W:0]     w_cand;
  logic [2:0]         w_pick_code;
  logic [4:0]         w_sides;
  logic               w_in_range;
  logic               w_retry_ok;
  logic               w_settled;
  logic [IDX_W-1:0]   w_ptr_next;

  // Round-robin search: first asserted request at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      if (!w_found && req[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_pick_code = req_die[w_pick*3 +: 3];
  assign w_sides     = sides_of(r_code);
  assign w_in_range  = (roller_result != 5'd0) && (roller_result <= w_sides);
  assign w_retry_ok  = r_retry < RTY_W'(MAX_RETRY);
  assign w_settled   = r_settle == SET_W'(SETTLE_CYC - 1);
  assign w_ptr_next  = (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode plus the strobes that depend on the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_next       = r_state;
    roller_reset = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_next = (sides_of(w_pick_code) != 5'd0) ? S_SETUP : S_DONE;
      S_SETUP: if (w_settled) w_next = S_ROLL;
      S_ROLL:  w_next = S_CHECK;
      S_CHECK: begin
        if (w_in_range) begin
          w_next = S_DONE;
        end else if (w_retry_ok) begin
          roller_reset = 1'b1;
          w_next       = S_SETUP;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction datapath: latch the winner, count settle cycles, capture results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_winner     <= '0;
      r_code       <= '0;
      r_settle     <= '0;
      r_retry      <= '0;
      r_err        <= 1'b0;
      r_result     <= '0;
      r_roll_count <= '0;
      r_roller_die <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner <= w_pick;
            r_code   <= w_pick_code;
            r_settle <= '0;
            if (sides_of(w_pick_code) != 5'd0) begin
              r_roller_die <= w_pick_code;
              r_err        <= 1'b0;
            end else begin
              r_err    <= 1'b1;
              r_result <= '0;
            end
          end
        end
        S_SETUP: r_settle <= r_settle + 1'b1;
        S_CHECK: begin
          if (w_in_range) begin
            r_result     <= roller_result;
            r_err        <= 1'b0;
            r_roll_count <= r_roll_count + 16'd1;
          end else if (w_retry_ok) begin
            r_retry  <= r_retry + 1'b1;
            r_settle <= '0;
          end else begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        S_DONE: begin
          r_retry <= '0;
          r_ptr   <= w_ptr_next;
        end
        default: ;
      endcase
    end
  end

  // Requester-facing and roller-facing outputs decoded from state.
  always_comb begin
    busy        = r_state != S_IDLE;
    gnt         = '0;
    done        = '0;
    if (r_state != S_IDLE) gnt[r_winner] = 1'b1;
    if (r_state == S_DONE) done[r_winner] = 1'b1;
    error       = (r_state == S_DONE) && r_err;
    roller_roll = r_state == S_ROLL;
  end

  assign result     = r_result;
  assign roll_count = r_roll_count;
  assign roller_die = r_roller_die;

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Scoreboard bench for dice_roll_scheduler: a reference model predicts the
// service order and outcome of each request batch, a roller stub replays
// planned samples, and a monitor compares every done pulse.
module tb_dice_roll_scheduler;

  localparam int N      = 4;
  localparam int SETTLE = 2;
  localparam int MAXR   = 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [3*N-1:0]   req_die;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic [4:0]       result;
  logic             error;
  logic             busy;
  logic [15:0]      roll_count;
  logic [2:0]       roller_die;
  logic             roller_roll;
  logic             roller_reset;
  logic [4:0]       roller_result;

  dice_roll_scheduler #(.NUM_REQ(N), .SETTLE_CYC(SETTLE), .MAX_RETRY(MAXR)) dut (
    .clock(clock), .reset(reset), .req(req), .req_die(req_die),
    .gnt(gnt), .done(done), .result(result), .error(error), .busy(busy),
    .roll_count(roll_count), .roller_die(roller_die), .roller_roll(roller_roll),
    .roller_reset(roller_reset), .roller_result(roller_result)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    logic [4:0]  result;
    logic        err;
    logic [15:0] count;
    int          rolls;
    int          resets;
    int          lat;
    int          start;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          m_ptr = 0;
  logic [15:0] m_count = 16'd0;
  int          sides_tab [8] = '{0, 4, 6, 8, 10, 12, 20, 0};
  logic [2:0]  die_code [N];
  logic [4:0]  plan [N][4];
  logic [N-1:0] drop_mask = '0;
  int          attempt, rolls_seen, resets_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: outcome of serving one requester given its planned samples.
  function automatic exp_t model(input int idx, input bit want_lat);
    exp_t e;
    int   s;
    bit   ok;
    s = sides_tab[die_code[idx]];
    e.idx = idx; e.result = 5'd0; e.err = 1'b1; e.rolls = 0; e.resets = 0;
    e.lat = -1; e.start = 0; e.count = 16'd0;
    if (s != 0) begin
      ok = 1'b0;
      for (int a = 0; a <= MAXR && !ok; a++) begin
        e.rolls = a + 1;
        if (int'(plan[idx][a]) >= 1 && int'(plan[idx][a]) <= s) begin
          ok = 1'b1; e.result = plan[idx][a]; e.err = 1'b0;
        end
      end
      e.resets = ok ? e.rolls - 1 : MAXR;
      if (want_lat) e.lat = SETTLE + 3 + (e.rolls - 1) * (SETTLE + 2);
    end else if (want_lat) begin
      e.lat = 1;
    end
    if (!e.err) m_count = m_count + 16'd1;
    e.count = m_count;
    return e;
  endfunction

  // Roller stub: replays the granted requester's planned samples per roll.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      roller_result <= 5'd0; attempt <= 0; rolls_seen <= 0; resets_seen <= 0;
    end else if (|done) begin
      attempt <= 0; rolls_seen <= 0; resets_seen <= 0;
    end else begin
      if (roller_roll) begin
        roller_result <= plan[oh_idx(gnt)][attempt];
        attempt       <= attempt + 1;
        rolls_seen    <= rolls_seen + 1;
      end
      if (roller_reset) begin
        roller_result <= 5'd0;
        resets_seen   <= resets_seen + 1;
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops one expectation per done pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (roller_roll) check("roller_die", 32'(roller_die), 32'(die_code[oh_idx(gnt)]));
      if (|done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_idx",   32'(done), 32'(1 << mon_e.idx));
          check("gnt_at_done", 32'(gnt), 32'(1 << mon_e.idx));
          check("result",     32'(result), 32'(mon_e.result));
          check("error",      32'(error), 32'(mon_e.err));
          check("roll_count", 32'(roll_count), 32'(mon_e.count));
          check("rolls",      rolls_seen, mon_e.rolls);
          check("resets",     resets_seen, mon_e.resets);
          if (mon_e.lat >= 0) check("latency", cyc - mon_e.start, mon_e.lat);
        end
      end
    end
  end

  task automatic set_plan(input int i, input logic [2:0] code, input logic [4:0] v0, input logic [4:0] v1);
    die_code[i] = code;
    plan[i][0] = v0; plan[i][1] = v1; plan[i][2] = 5'd0; plan[i][3] = 5'd0;
  endtask

  task automatic rand_plan(input int i);
    int s;
    if ($urandom_range(0, 7) == 0) die_code[i] = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd0;
    else                           die_code[i] = 3'($urandom_range(1, 6));
    s = sides_tab[die_code[i]];
    for (int a = 0; a < 4; a++) begin
      if (s != 0 && $urandom_range(0, 9) < 6) plan[i][a] = 5'($urandom_range(1, s));
      else if ($urandom_range(0, 1) != 0)     plan[i][a] = 5'd0;
      else                                    plan[i][a] = 5'($urandom_range(s + 1, 31));
    end
  endtask

  // Held requests are served once each, cyclically from the model pointer.
  task automatic push_expect(input logic [N-1:0] mask, input bit want_lat);
    exp_t e;
    int   last = -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (mask[i]) begin
        e = model(i, want_lat);
        e.start = cyc;
        exp_q.push_back(e);
        last = i;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % N;
  endtask

  task automatic issue(input logic [N-1:0] mask, input logic [N-1:0] drop, input bit want_lat);
    push_expect(mask, want_lat);
    drop_mask = drop;
    for (int i = 0; i < N; i++) req_die[3*i +: 3] = die_code[i];
    req = mask;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 400) begin
      @(negedge clock);
      for (int i = 0; i < N; i++)
        if (done[i] || (gnt[i] && drop_mask[i])) req[i] = 1'b0;
      t++;
    end
    if (t >= 400) begin
      check("drain_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    req = '0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; req = '0; req_die = '0;
    for (int i = 0; i < N; i++) set_plan(i, 3'd1, 5'd1, 5'd1);
    repeat (3) @(negedge clock);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_roll_count", 32'(roll_count), 32'd0);
    check("rst_roller", 32'({roller_die, roller_roll, roller_reset}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single requester 0, d20, sample 17.
    set_plan(0, 3'b110, 5'd17, 5'd0);
    issue(4'b0001, 4'b0000, 1'b1);
    @(negedge clock);
    check("t1_gnt", 32'(gnt), 32'd1);
    drain();

    // All four requesters, d4, sample 3: served cyclically.
    for (int i = 0; i < N; i++) set_plan(i, 3'b001, 5'd3, 5'd3);
    issue(4'b1111, 4'b0000, 1'b0);
    drain();

    // Retry paths on requester 2.
    set_plan(2, 3'b001, 5'd9, 5'd2);
    issue(4'b0100, 4'b0000, 1'b1);
    drain();
    set_plan(2, 3'b001, 5'd9, 5'd9);
    issue(4'b0100, 4'b0000, 1'b1);
    drain();

    // Invalid die code on requester 1.
    set_plan(1, 3'b111, 5'd3, 5'd3);
    issue(4'b0010, 4'b0000, 1'b1);
    drain();

    // Reset during SETUP: pointer was 2, so requester 3 is granted first.
    set_plan(0, 3'b010, 5'd5, 5'd5);
    set_plan(3, 3'b011, 5'd7, 5'd7);
    issue(4'b1001, 4'b0000, 1'b0);
    @(negedge clock);
    check("pre_rst_gnt", 32'(gnt), 32'b1000);
    reset = 1'b1;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_roll_count", 32'(roll_count), 32'd0);
    exp_q.delete();
    m_ptr = 0;
    m_count = 16'd0;
    @(negedge clock);
    push_expect(4'b1001, 1'b0);
    reset = 1'b0;
    drain();

    // roll_count wrap.
    force dut.r_roll_count = 16'hFFFF;
    @(negedge clock);
    release dut.r_roll_count;
    m_count = 16'hFFFF;
    set_plan(1, 3'b110, 5'd20, 5'd20);
    issue(4'b0010, 4'b0000, 1'b0);
    drain();

    // Randomized batches, some requesters dropping req once granted.
    for (int b = 0; b < 40; b++) begin
      logic [N-1:0] mask;
      for (int i = 0; i < N; i++) rand_plan(i);
      mask = N'($urandom_range(1, (1 << N) - 1));
      issue(mask, N'($urandom) & mask, 1'b0);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
